// File: rtl/blackjack_table.sv
// blackjack_table: round controller for the blackjack core.
// It handles 1..NUM_PLAYERS seats plus the dealer. It deals the opening cards, runs each
// player's hit/stand turn, plays the dealer AI and settles the results.
//
// Ports:
//   i_clk, i_reset     clock; synchronous active-low reset
//   i_start            start a round (only honoured in IDLE/DONE)
//   i_cmd_valid/i_cmd  player command strobe; 1 = hit, 0 = stand
//   o_cmd_ready        command accepted this cycle when i_cmd_valid is high
//   o_card_req         card request to deck (one outstanding at most)
//   i_card_valid/i_card deck reply, rank 1..13
//   o_state            IDLE=0 DEAL=1 PLAYER=2 DEALER=3 SETTLE=4 DONE=5
//   o_turn             active seat; NUM_PLAYERS means the dealer
//   o_player_sum       best sum per player, seat 0 in the LSBs
//   o_player_count     cards held per player
//   o_dealer_sum       dealer best sum
//   o_result           per player: 00 none, 01 lose, 10 win, 11 push
//   o_done             high in DONE
module blackjack_table #(
    parameter int NUM_PLAYERS  = 1,
    parameter int MAX_CARDS    = 5,
    parameter int DEALER_STAND = 17,
    localparam int SUM_W  = $clog2(10 * MAX_CARDS + 11),
    localparam int CNT_W  = $clog2(MAX_CARDS + 1),
    localparam int TURN_W = $clog2(NUM_PLAYERS + 1)
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_start,
    input  logic                         i_cmd_valid,
    input  logic                         i_cmd,
    output logic                         o_cmd_ready,
    output logic                         o_card_req,
    input  logic                         i_card_valid,
    input  logic [3:0]                   i_card,
    output logic [2:0]                   o_state,
    output logic [TURN_W-1:0]            o_turn,
    output logic [NUM_PLAYERS*SUM_W-1:0] o_player_sum,
    output logic [NUM_PLAYERS*CNT_W-1:0] o_player_count,
    output logic [SUM_W-1:0]             o_dealer_sum,
    output logic [NUM_PLAYERS*2-1:0]     o_result,
    output logic                         o_done
);

    localparam int Hands = NUM_PLAYERS + 1;
    localparam logic [TURN_W-1:0] LastSeat   = TURN_W'(NUM_PLAYERS - 1);
    localparam logic [TURN_W-1:0] DealerSeat = TURN_W'(NUM_PLAYERS);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StDeal   = 3'd1,
        StPlayer = 3'd2,
        StDealer = 3'd3,
        StSettle = 3'd4,
        StDone   = 3'd5
    } stateT;

    stateT             state;
    logic [TURN_W-1:0] turn;
    logic [TURN_W-1:0] dealSeat;
    logic              dealRound;
    logic              cardReq;
    logic [SUM_W-1:0]  hardSum   [Hands];
    logic              hasAce    [Hands];
    logic [CNT_W-1:0]  cardCount [Hands];
    logic [1:0]        result    [NUM_PLAYERS];

    logic [SUM_W-1:0]  bestSum   [Hands];
    logic              isBust    [Hands];
    logic              isFull    [Hands];
    logic [1:0]        settleRes [NUM_PLAYERS];
    logic              allBust;
    logic              turnDone;
    logic              cardTaken;
    logic [TURN_W-1:0] curSeat;

    // Ace counts 1 here; the soft +10 is applied when forming the best sum.
    function automatic logic [SUM_W-1:0] cardVal(input logic [3:0] rank);
        if (rank >= 4'd1 && rank <= 4'd10) begin
            return SUM_W'(rank);
        end
        return SUM_W'(10);
    endfunction

    assign cardTaken = cardReq && i_card_valid;
    // During the deal the receiving hand rotates independently of o_turn.
    assign curSeat   = (state == StDeal) ? dealSeat : turn;

    always_comb begin
        for (int h = 0; h < Hands; h++) begin
            if (hasAce[h] && hardSum[h] <= SUM_W'(11)) begin
                bestSum[h] = hardSum[h] + SUM_W'(10);
            end else begin
                bestSum[h] = hardSum[h];
            end
            isBust[h] = bestSum[h] > SUM_W'(21);
            isFull[h] = cardCount[h] == CNT_W'(MAX_CARDS);
        end
    end

    always_comb begin
        allBust = 1'b1;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            allBust = allBust & isBust[p];
            if (isBust[p]) begin
                settleRes[p] = 2'b01;
            end else if (isBust[DealerSeat]) begin
                settleRes[p] = 2'b10;
            end else if (bestSum[p] > bestSum[DealerSeat]) begin
                settleRes[p] = 2'b10;
            end else if (bestSum[p] == bestSum[DealerSeat]) begin
                settleRes[p] = 2'b11;
            end else begin
                settleRes[p] = 2'b01;
            end
        end
    end

    assign turnDone = (bestSum[turn] >= SUM_W'(21)) || isFull[turn];

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state     <= StIdle;
            turn      <= '0;
            dealSeat  <= '0;
            dealRound <= 1'b0;
            cardReq   <= 1'b0;
            for (int h = 0; h < Hands; h++) begin
                hardSum[h]   <= '0;
                hasAce[h]    <= 1'b0;
                cardCount[h] <= '0;
            end
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                result[p] <= 2'b00;
            end
        end else begin
            if (cardTaken) begin
                hardSum[curSeat]   <= hardSum[curSeat] + cardVal(i_card);
                hasAce[curSeat]    <= hasAce[curSeat] | (i_card == 4'd1);
                cardCount[curSeat] <= cardCount[curSeat] + CNT_W'(1);
                cardReq            <= 1'b0;
            end

            case (state)
                StIdle, StDone: begin
                    if (i_start) begin
                        for (int h = 0; h < Hands; h++) begin
                            hardSum[h]   <= '0;
                            hasAce[h]    <= 1'b0;
                            cardCount[h] <= '0;
                        end
                        for (int p = 0; p < NUM_PLAYERS; p++) begin
                            result[p] <= 2'b00;
                        end
                        turn      <= '0;
                        dealSeat  <= '0;
                        dealRound <= 1'b0;
                        state     <= StDeal;
                    end
                end

                StDeal: begin
                    if (cardTaken) begin
                        if (dealSeat == DealerSeat) begin
                            dealSeat  <= '0;
                            dealRound <= 1'b1;
                            if (dealRound) begin
                                state <= StPlayer;
                            end
                        end else begin
                            dealSeat <= dealSeat + TURN_W'(1);
                        end
                    end else if (!cardReq) begin
                        cardReq <= 1'b1;
                    end
                end

                StPlayer: begin
                    // Hands are re-evaluated only once no card is pending, so the
                    // check always sees the hand including the last card drawn.
                    if (!cardReq) begin
                        if (turnDone || (i_cmd_valid && !i_cmd)) begin
                            if (turn == LastSeat) begin
                                turn  <= DealerSeat;
                                state <= StDealer;
                            end else begin
                                turn <= turn + TURN_W'(1);
                            end
                        end else if (i_cmd_valid) begin
                            cardReq <= 1'b1;
                        end
                    end
                end

                StDealer: begin
                    if (!cardReq) begin
                        if (allBust || bestSum[DealerSeat] >= SUM_W'(DEALER_STAND) ||
                            isFull[DealerSeat]) begin
                            state <= StSettle;
                        end else begin
                            cardReq <= 1'b1;
                        end
                    end
                end

                StSettle: begin
                    for (int p = 0; p < NUM_PLAYERS; p++) begin
                        result[p] <= settleRes[p];
                    end
                    state <= StDone;
                end

                default: state <= StIdle;
            endcase
        end
    end

    assign o_state     = state;
    assign o_turn      = turn;
    assign o_card_req  = cardReq;
    assign o_done      = (state == StDone);
    // A seat that is about to auto-advance must not swallow a command.
    assign o_cmd_ready = (state == StPlayer) && !cardReq && !turnDone;
    assign o_dealer_sum = bestSum[DealerSeat];

    always_comb begin
        o_player_sum   = '0;
        o_player_count = '0;
        o_result       = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            o_player_sum[p*SUM_W +: SUM_W]   = bestSum[p];
            o_player_count[p*CNT_W +: CNT_W] = cardCount[p];
            o_result[p*2 +: 2]               = result[p];
        end
    end

endmodule

// File: tb/tb_blackjack_table.sv
module tb_blackjack_table;

    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    // Single-seat table
    logic       start1, cmdV1, cmd1, rdy1, req1, cv1, done1;
    logic [3:0] card1;
    logic [2:0] state1, pcnt1;
    logic [0:0] turn1;
    logic [5:0] psum1, dsum1;
    logic [1:0] res1;

    // Two-seat table
    logic        start2, cmdV2, cmd2, rdy2, req2, cv2, done2;
    logic [3:0]  card2;
    logic [2:0]  state2;
    logic [1:0]  turn2;
    logic [11:0] psum2;
    logic [5:0]  pcnt2, dsum2;
    logic [3:0]  res2;

    blackjack_table #(.NUM_PLAYERS(1), .MAX_CARDS(5), .DEALER_STAND(17)) u1 (
        .i_clk(clk), .i_reset(rstN), .i_start(start1), .i_cmd_valid(cmdV1), .i_cmd(cmd1),
        .o_cmd_ready(rdy1), .o_card_req(req1), .i_card_valid(cv1), .i_card(card1),
        .o_state(state1), .o_turn(turn1), .o_player_sum(psum1), .o_player_count(pcnt1),
        .o_dealer_sum(dsum1), .o_result(res1), .o_done(done1)
    );

    blackjack_table #(.NUM_PLAYERS(2), .MAX_CARDS(5), .DEALER_STAND(17)) u2 (
        .i_clk(clk), .i_reset(rstN), .i_start(start2), .i_cmd_valid(cmdV2), .i_cmd(cmd2),
        .o_cmd_ready(rdy2), .o_card_req(req2), .i_card_valid(cv2), .i_card(card2),
        .o_state(state2), .o_turn(turn2), .o_player_sum(psum2), .o_player_count(pcnt2),
        .o_dealer_sum(dsum2), .o_result(res2), .o_done(done2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // One full round on the single-seat table; cards listed LSB nibble first.
    typedef struct {
        logic [31:0] cards;
        int          ncards;
        logic [7:0]  cmds;
        int          ncmd;
        int          lat;
        logic [5:0]  pSum;
        logic [2:0]  pCnt;
        logic [5:0]  dSum;
        logic [1:0]  res;
    } vecT;

    vecT vecs[9];

    task automatic runRow(input int idx, input vecT v);
        int ci = 0;
        int mi = 0;
        int waitCnt = 0;
        logic gave = 1'b0;
        logic [2:0] snapState = '0;
        logic [2:0] snapCnt = '0;
        logic [5:0] snapD = '0;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int cyc = 0; cyc < 400 && !done1; cyc++) begin
            cv1 = 1'b0;
            cmdV1 = 1'b0;
            if (gave) begin
                check($sformatf("row%0d reqDrop", idx), req1, 0);
                gave = 1'b0;
            end
            if (req1) begin
                if (waitCnt < v.lat) begin
                    if (waitCnt == 0) begin
                        snapState = state1;
                        snapCnt = pcnt1;
                        snapD = dsum1;
                    end else begin
                        check($sformatf("row%0d stallState", idx), state1, snapState);
                        check($sformatf("row%0d stallCnt", idx), pcnt1, snapCnt);
                        check($sformatf("row%0d stallDealer", idx), dsum1, snapD);
                    end
                    waitCnt++;
                end else begin
                    card1 = v.cards[ci*4 +: 4];
                    ci++;
                    cv1 = 1'b1;
                    gave = 1'b1;
                    waitCnt = 0;
                end
            end
            if (rdy1 && mi < v.ncmd) begin
                cmdV1 = 1'b1;
                cmd1 = v.cmds[mi];
                mi++;
            end
            @(negedge clk);
        end
        cv1 = 1'b0;
        cmdV1 = 1'b0;
        check($sformatf("row%0d done", idx), done1, 1);
        check($sformatf("row%0d state", idx), state1, 5);
        check($sformatf("row%0d playerSum", idx), psum1, v.pSum);
        check($sformatf("row%0d playerCount", idx), pcnt1, v.pCnt);
        check($sformatf("row%0d dealerSum", idx), dsum1, v.dSum);
        check($sformatf("row%0d result", idx), res1, v.res);
        check($sformatf("row%0d cardsUsed", idx), ci, v.ncards);
        check($sformatf("row%0d cmdsUsed", idx), mi, v.ncmd);
    endtask

    task automatic feed(input int sel, input logic [3:0] c);
        int n = 0;
        while (!(sel != 0 ? req2 : req1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reqWait", n < 100, 1);
        if (sel != 0) begin
            cv2 = 1'b1;
            card2 = c;
        end else begin
            cv1 = 1'b1;
            card1 = c;
        end
        @(negedge clk);
        cv1 = 1'b0;
        cv2 = 1'b0;
    endtask

    task automatic sendCmd(input int sel, input logic c);
        int n = 0;
        while (!(sel != 0 ? rdy2 : rdy1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("readyWait", n < 100, 1);
        if (sel != 0) begin
            cmdV2 = 1'b1;
            cmd2 = c;
        end else begin
            cmdV1 = 1'b1;
            cmd1 = c;
        end
        @(negedge clk);
        cmdV1 = 1'b0;
        cmdV2 = 1'b0;
    endtask

    task automatic waitDone(input int sel);
        int n = 0;
        while (!(sel != 0 ? done2 : done1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("doneWait", n < 200, 1);
    endtask

    initial begin
        vecs[0] = '{32'h00057D51, 5, 8'h00, 0, 0, 6'd21, 3'd2, 6'd17, 2'b10};
        vecs[1] = '{32'h00099691, 5, 8'h01, 2, 0, 6'd16, 3'd3, 6'd18, 2'b01};
        vecs[2] = '{32'h0008869A, 5, 8'h01, 1, 0, 6'd24, 3'd3, 6'd17, 2'b01};
        vecs[3] = '{32'h00057D51, 5, 8'h00, 0, 3, 6'd21, 3'd2, 6'd17, 2'b10};
        vecs[4] = '{32'h000077AA, 4, 8'h00, 1, 0, 6'd17, 3'd2, 6'd17, 2'b11};
        vecs[5] = '{32'h000969AA, 5, 8'h00, 1, 0, 6'd19, 3'd2, 6'd25, 2'b10};
        vecs[6] = '{32'h02226212, 7, 8'h07, 3, 0, 6'd10, 3'd5, 6'd17, 2'b01};
        vecs[7] = '{32'h0222292A, 7, 8'h00, 1, 0, 6'd19, 3'd2, 6'd10, 2'b10};
        vecs[8] = '{32'h000F505E, 5, 8'h00, 1, 0, 6'd20, 3'd2, 6'd20, 2'b11};

        rstN = 1'b0;
        {start1, cmdV1, cmd1, cv1} = '0;
        {start2, cmdV2, cmd2, cv2} = '0;
        card1 = '0;
        card2 = '0;
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);

        check("rst state", state1, 0);
        check("rst req", req1, 0);
        check("rst ready", rdy1, 0);
        check("rst done", done1, 0);
        check("rst sums", {psum1, dsum1, res1, pcnt1, turn1}, 0);
        check("rst state2", state2, 0);

        for (int i = 0; i < 9; i++) begin
            runRow(i, vecs[i]);
        end

        // Reset in the middle of the deal with a request outstanding.
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        feed(0, 4'd10);
        feed(0, 4'd9);
        begin
            int n = 0;
            while (!req1 && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        check("midDeal req", req1, 1);
        check("midDeal state", state1, 1);
        check("midDeal sum", psum1, 10);
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        check("midRst state", state1, 0);
        check("midRst req", req1, 0);
        check("midRst sums", {psum1, dsum1, res1, pcnt1}, 0);
        check("midRst done", done1, 0);
        @(negedge clk);

        // Soft 17 hit turning hard 16; stray card and stray start ignored.
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        feed(0, 4'd1);
        feed(0, 4'd9);
        feed(0, 4'd6);
        feed(0, 4'd9);
        @(negedge clk);
        check("soft17 sum", psum1, 17);
        sendCmd(0, 1'b1);
        feed(0, 4'd9);
        check("hard16 state", state1, 2);
        check("hard16 ready", rdy1, 1);
        check("hard16 sum", psum1, 16);
        check("hard16 count", pcnt1, 3);
        cv1 = 1'b1;
        card1 = 4'd5;
        @(negedge clk);
        cv1 = 1'b0;
        check("strayCard count", pcnt1, 3);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("strayStart state", state2 == 0 ? state1 : state1, 2);
        sendCmd(0, 1'b0);
        waitDone(0);
        check("hard16 result", res1, 2'b01);
        check("hard16 dealer", dsum1, 18);

        // Two seats: seat 0 fills its hand, seat 1 stands on 20, dealer 20.
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        feed(1, 4'd2);
        feed(1, 4'd10);
        feed(1, 4'd10);
        feed(1, 4'd2);
        feed(1, 4'd10);
        feed(1, 4'd10);
        for (int k = 0; k < 3; k++) begin
            sendCmd(1, 1'b1);
            feed(1, 4'd2);
        end
        begin
            int n = 0;
            while (!rdy2 && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        check("two turn", turn2, 1);
        check("two p0count", pcnt2[2:0], 5);
        sendCmd(1, 1'b0);
        waitDone(1);
        check("two result", res2, 4'b1101);
        check("two sums", psum2, {6'd20, 6'd10});
        check("two counts", pcnt2, {3'd2, 3'd5});
        check("two dealer", dsum2, 20);
        check("two turnDealer", turn2, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
